// File: rtl/simd_vector_core.sv
// LANES-wide SIMD core: vector register file, two-stage ALU pipeline with
// valid/ready issue and result handshakes, lane masks, saturation and forwarding.
module simd_vector_core #(
  parameter int LANES  = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 6,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_en,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [LANES*WIDTH-1:0]   ld_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic                     sat,
  input  logic [ADDR_W-1:0]        ra,
  input  logic [ADDR_W-1:0]        rb,
  input  logic [ADDR_W-1:0]        rd,
  input  logic [LANES-1:0]         lane_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic [ADDR_W-1:0]        out_rd,
  output logic [LANES-1:0]         out_sat
);
  localparam int VW = LANES * WIDTH;

  logic [VW-1:0]     rf_r [DEPTH];
  logic              s1_valid_r;
  logic [2:0]        s1_op_r;
  logic              s1_sat_r;
  logic [ADDR_W-1:0] s1_rd_r;
  logic [LANES-1:0]  s1_mask_r;
  logic [VW-1:0]     s1_a_r;
  logic [VW-1:0]     s1_b_r;
  logic              out_valid_r;
  logic [VW-1:0]     out_data_r;
  logic [ADDR_W-1:0] out_rd_r;
  logic [LANES-1:0]  out_sat_r;

  logic              adv_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              wb_s;
  logic              rd_ok_s;
  logic              fwd_a_s;
  logic              fwd_b_s;
  logic [VW-1:0]     rf_a_s;
  logic [VW-1:0]     rf_b_s;
  logic [VW-1:0]     opa_s;
  logic [VW-1:0]     opb_s;
  logic [VW-1:0]     alu_res_s;
  logic [LANES-1:0]  alu_sat_s;

  // Returns {clamped, result} for one unsigned lane.
  function automatic logic [WIDTH:0] alu_lane(input logic [2:0] op_f, input logic sat_f,
                                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     res;
    sum  = {1'b0, a} + {1'b0, b};
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (op_f)
      3'b000:  res = (sat_f && sum[WIDTH]) ? {1'b1, {WIDTH{1'b1}}} : {1'b0, sum[WIDTH-1:0]};
      3'b001:  res = (sat_f && (a < b)) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, a - b};
      3'b010:  res = {1'b0, a & b};
      3'b011:  res = {1'b0, a | b};
      3'b100:  res = {1'b0, a ^ b};
      3'b101:  res = {1'b0, (a < b) ? a : b};
      3'b110:  res = {1'b0, (a > b) ? a : b};
      3'b111:  res = (sat_f && (|prod[2*WIDTH-1:WIDTH])) ? {1'b1, {WIDTH{1'b1}}}
                                                         : {1'b0, prod[WIDTH-1:0]};
      default: res = {(WIDTH+1){1'b0}};
    endcase
    return res;
  endfunction

  // Handshake control: a stalled output freezes S1, the output register and writeback.
  always_comb begin
    adv_s      = !out_valid_r || out_ready;
    in_ready_s = !ld_en && (!s1_valid_r || adv_s);
    accept_s   = in_valid && in_ready_s;
    wb_s       = adv_s && s1_valid_r;
  end

  // Register-file read ports; out-of-range addresses match no entry and read zero.
  always_comb begin
    rf_a_s  = {VW{1'b0}};
    rf_b_s  = {VW{1'b0}};
    rd_ok_s = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      rf_a_s  = (ra == ADDR_W'(e)) ? rf_r[e] : rf_a_s;
      rf_b_s  = (rb == ADDR_W'(e)) ? rf_r[e] : rf_b_s;
      rd_ok_s = rd_ok_s | (s1_rd_r == ADDR_W'(e));
    end
  end

  // Per-lane ALU on S1 contents; masked lanes produce zero and no clamp flag.
  always_comb begin
    alu_res_s = {VW{1'b0}};
    alu_sat_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      logic [WIDTH:0] lane_v;
      lane_v = alu_lane(s1_op_r, s1_sat_r, s1_a_r[i*WIDTH +: WIDTH], s1_b_r[i*WIDTH +: WIDTH]);
      alu_res_s[i*WIDTH +: WIDTH] = s1_mask_r[i] ? lane_v[WIDTH-1:0] : {WIDTH{1'b0}};
      alu_sat_s[i] = s1_mask_r[i] & lane_v[WIDTH];
    end
  end

  // Forwarding: only lanes the S1 instruction will actually write bypass the RF.
  always_comb begin
    fwd_a_s = s1_valid_r && rd_ok_s && (s1_rd_r == ra);
    fwd_b_s = s1_valid_r && rd_ok_s && (s1_rd_r == rb);
    opa_s   = rf_a_s;
    opb_s   = rf_b_s;
    for (int i = 0; i < LANES; i++) begin
      opa_s[i*WIDTH +: WIDTH] = (fwd_a_s && s1_mask_r[i]) ? alu_res_s[i*WIDTH +: WIDTH]
                                                          : rf_a_s[i*WIDTH +: WIDTH];
      opb_s[i*WIDTH +: WIDTH] = (fwd_b_s && s1_mask_r[i]) ? alu_res_s[i*WIDTH +: WIDTH]
                                                          : rf_b_s[i*WIDTH +: WIDTH];
    end
  end

  // Pipeline registers: S1 capture on accept, output register load on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_op_r     <= 3'b000;
      s1_sat_r    <= 1'b0;
      s1_rd_r     <= {ADDR_W{1'b0}};
      s1_mask_r   <= {LANES{1'b0}};
      s1_a_r      <= {VW{1'b0}};
      s1_b_r      <= {VW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {VW{1'b0}};
      out_rd_r    <= {ADDR_W{1'b0}};
      out_sat_r   <= {LANES{1'b0}};
    end else begin
      if (accept_s) begin
        s1_valid_r <= 1'b1;
        s1_op_r    <= op;
        s1_sat_r   <= sat;
        s1_rd_r    <= rd;
        s1_mask_r  <= lane_mask;
        s1_a_r     <= opa_s;
        s1_b_r     <= opb_s;
      end else if (adv_s) begin
        s1_valid_r <= 1'b0;
      end
      if (adv_s) begin
        out_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          out_data_r <= alu_res_s;
          out_rd_r   <= s1_rd_r;
          out_sat_r  <= alu_sat_s;
        end
      end
    end
  end

  // Register file: a full-vector load overrides a same-address masked writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) rf_r[e] <= {VW{1'b0}};
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ld_en && (ld_addr == ADDR_W'(e))) begin
          rf_r[e] <= ld_data;
        end else if (wb_s && (s1_rd_r == ADDR_W'(e))) begin
          for (int i = 0; i < LANES; i++) begin
            if (s1_mask_r[i]) rf_r[e][i*WIDTH +: WIDTH] <= alu_res_s[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_rd    = out_rd_r;
  assign out_sat   = out_sat_r;
endmodule

// File: tb/tb_simd_vector_core.sv
// Directed bench for simd_vector_core: a sequential register-file model feeds a
// scoreboard queue at issue time; a monitor pops and compares delivered results.
module tb_simd_vector_core;
  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 6;
  localparam int AW    = 3;
  localparam int MAXV  = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ld_en = 1'b0;
  logic [AW-1:0]    ld_addr = '0;
  logic [31:0]      ld_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = '0;
  logic             sat = 1'b0;
  logic [AW-1:0]    ra = '0, rb = '0, rd = '0;
  logic [LANES-1:0] lane_mask = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [AW-1:0]    out_rd;
  logic [LANES-1:0] out_sat;

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] rd;
    logic [3:0]    sat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mrf[8];
  int          checks = 0;
  int          errors = 0;

  simd_vector_core #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .sat(sat), .ra(ra), .rb(rb),
    .rd(rd), .lane_mask(lane_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_sat(out_sat));

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction

  function automatic logic [31:0] mread(input int a);
    return (a < DEPTH) ? mrf[a] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference lane behaviour, written directly from the operation definitions.
  task automatic model_lane(input int o, input bit s, input int a, input int b,
                            output int r, output bit c);
    int t;
    c = 1'b0;
    case (o)
      0: begin t = a + b; if (s && t > MAXV) begin r = MAXV; c = 1'b1; end else r = t % 256; end
      1: begin if (a < b) begin if (s) begin r = 0; c = 1'b1; end else r = a - b + 256; end
               else r = a - b; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a < b) ? a : b;
      6: r = (a > b) ? a : b;
      default: begin t = a * b; if (s && t > MAXV) begin r = MAXV; c = 1'b1; end else r = t % 256; end
    endcase
  endtask

  task automatic load(input int a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (a < DEPTH) mrf[a] = d;
  endtask

  task automatic issue(input int o, input bit s, input int a, input int b, input int d,
                       input logic [3:0] m);
    int   n;
    exp_t e;
    logic [31:0] va, vb, nv;
    in_valid = 1'b1; op = 3'(o); sat = s; ra = AW'(a); rb = AW'(b); rd = AW'(d); lane_mask = m;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("issue_timeout", 32'(in_ready), 32'h1);
      in_valid = 1'b0;
      return;
    end
    va = mread(a); vb = mread(b); nv = mread(d);
    e.data = '0; e.sat = '0; e.rd = AW'(d);
    for (int i = 0; i < LANES; i++) begin
      int r; bit c;
      model_lane(o, s, int'(va[i*8 +: 8]), int'(vb[i*8 +: 8]), r, c);
      if (m[i]) begin
        e.data[i*8 +: 8] = r[7:0];
        e.sat[i] = c;
        nv[i*8 +: 8] = r[7:0];
      end
    end
    if (d < DEPTH) mrf[d] = nv;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin @(posedge clk); n++; end
    #1;
    chk("drain_empty", 32'(sb.size()), 32'h0);
  endtask

  // Result monitor: compares each delivered result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_rd", 32'(out_rd), 32'(e.rd));
        chk("out_sat", 32'(out_sat), 32'(e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) mrf[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_rd", 32'(out_rd), 32'h0);
    chk("rst_out_sat", 32'(out_sat), 32'h0);
    @(posedge clk); #1;

    // Basic ADD with latency check
    load(0, pack(10, 20, 30, 40));
    load(1, pack(5, 5, 5, 5));
    issue(0, 1'b0, 0, 1, 2, 4'b1111);
    @(negedge clk);
    chk("lat_not_yet", 32'(out_valid), 32'h0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'h1);
    drain();

    // Saturation and wrap
    load(0, pack(250, 250, 250, 250));
    load(1, pack(10, 10, 10, 10));
    issue(0, 1'b1, 0, 1, 2, 4'b1111);
    issue(0, 1'b0, 0, 1, 3, 4'b1111);
    issue(1, 1'b1, 1, 0, 4, 4'b1111);
    issue(7, 1'b0, 0, 1, 5, 4'b1111);
    issue(7, 1'b1, 0, 1, 5, 4'b1111);
    issue(1, 1'b0, 1, 0, 5, 4'b1111);
    drain();
    chk("model_sat_add", mrf[2], pack(255, 255, 255, 255));
    chk("model_mul_wrap", mread(5), pack(16, 16, 16, 16));

    // Back-to-back RAW forwarding, full and partial mask
    load(0, pack(10, 20, 30, 40));
    load(1, pack(5, 5, 5, 5));
    issue(0, 1'b0, 0, 1, 2, 4'b1111);
    issue(0, 1'b0, 2, 1, 3, 4'b1111);
    drain();
    chk("raw_full_r3", mrf[3], pack(20, 30, 40, 50));
    load(2, pack(100, 100, 100, 100));
    issue(0, 1'b0, 0, 1, 2, 4'b0101);
    issue(0, 1'b0, 2, 1, 3, 4'b1111);
    drain();
    chk("raw_mask_r3", mrf[3], pack(20, 105, 40, 105));

    // Masked MAX, then read r4 back through OR
    load(4, pack(9, 9, 9, 9));
    issue(6, 1'b0, 0, 1, 4, 4'b0101);
    issue(3, 1'b0, 4, 4, 5, 4'b1111);
    drain();
    chk("mask_r4", mrf[4], pack(10, 9, 30, 9));

    // Back-pressure: two accepted, third stalls with output held
    out_ready = 1'b0;
    issue(0, 1'b0, 0, 1, 2, 4'b1111);
    issue(4, 1'b0, 0, 1, 3, 4'b1111);
    in_valid = 1'b1; op = 3'b001; sat = 1'b0; ra = 3'd0; rb = 3'd1; rd = 3'd4; lane_mask = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_hold_data", out_data, sb[0].data);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(1, 1'b0, 0, 1, 4, 4'b1111);
    drain();

    // Load blocks issue in the same cycle
    in_valid = 1'b1; op = 3'b000; ra = 3'd0; rb = 3'd1; rd = 3'd5;
    ld_en = 1'b1; ld_addr = 3'd3; ld_data = pack(1, 2, 3, 4);
    @(negedge clk);
    chk("ld_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    ld_en = 1'b0; in_valid = 1'b0;
    mrf[3] = pack(1, 2, 3, 4);

    // Load wins over a same-cycle writeback to the same register
    issue(0, 1'b0, 0, 1, 2, 4'b1111);
    load(2, pack(77, 77, 77, 77));
    issue(3, 1'b0, 2, 3, 5, 4'b1111);
    drain();
    chk("ld_wins_r2", mrf[2], pack(77, 77, 77, 77));

    // Out-of-range destination is not written nor forwarded; reads return zero
    issue(3, 1'b0, 0, 0, 7, 4'b1111);
    issue(3, 1'b0, 7, 1, 5, 4'b1111);
    issue(3, 1'b0, 6, 6, 4, 4'b1111);
    drain();

    // Reset with S1 and output both occupied
    out_ready = 1'b0;
    issue(0, 1'b0, 0, 1, 2, 4'b1111);
    issue(0, 1'b0, 0, 1, 3, 4'b1111);
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 8; i++) mrf[i] = '0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    chk("post_rst_out_data", out_data, 32'h0);
    @(posedge clk); #1;
    issue(3, 1'b0, 0, 2, 5, 4'b1111);
    issue(3, 1'b0, 3, 4, 5, 4'b1111);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
